// File: rtl/pwm_pkg.sv
// Shared PWM definitions: capture FSM states and the duty-cycle percent scale
// (same encoding the PWM generator's duty_cycle input uses).
package pwm_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } state_t;

  localparam int unsigned PERCENT_SCALE = 100;

endpackage

// File: rtl/pwm_div.sv
// Iterative restoring unsigned divider, one quotient bit per cycle.
// start is accepted only while not busy; done is a one-cycle pulse with quot valid.
module pwm_div #(
  parameter int unsigned NUM_W  = 15,
  parameter int unsigned DEN_W  = 8,
  parameter int unsigned QUOT_W = NUM_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [NUM_W-1:0]  num,
  input  logic [DEN_W-1:0]  den,
  output logic              busy,
  output logic              done,
  output logic [QUOT_W-1:0] quot
);

  localparam int unsigned CW = $clog2(NUM_W + 1);

  logic             run;
  logic [CW-1:0]    count;
  logic [NUM_W-1:0] q, q_src, q_n;
  logic [DEN_W-1:0] rem, rem_src, rem_n, den_r, den_src;
  logic [DEN_W:0]   shifted, den_ext;
  logic             load, ge;

  // The load cycle already produces the first quotient bit from the raw operands.
  always_comb begin
    load    = start & ~busy;
    rem_src = load ? '0  : rem;
    q_src   = load ? num : q;
    den_src = load ? den : den_r;
    shifted = {rem_src, q_src[NUM_W-1]};
    den_ext = {1'b0, den_src};
    ge      = (shifted >= den_ext);
    rem_n   = ge ? DEN_W'(shifted - den_ext) : shifted[DEN_W-1:0];
    q_n     = {q_src[NUM_W-2:0], ge};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      run   <= 1'b0;
      done  <= 1'b0;
      count <= '0;
      q     <= '0;
      rem   <= '0;
      den_r <= '0;
    end else begin
      done <= 1'b0;
      if (load) begin
        run   <= 1'b1;
        den_r <= den;
        q     <= q_n;
        rem   <= rem_n;
        count <= CW'(NUM_W - 1);
      end else if (run) begin
        q     <= q_n;
        rem   <= rem_n;
        count <= count - 1'b1;
        if (count == CW'(1)) begin
          run  <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end

  // Held busy through the done cycle so a result is never overwritten as it is published.
  assign busy = run | done;
  assign quot = q[QUOT_W-1:0];

endmodule

// File: rtl/pwm_capture.sv
// PWM capture: measures period, high time and integer duty percent of an async input.
// Optional glitch filter enabled by defining PWM_CAP_FILTER_EN.
module pwm_capture
  import pwm_pkg::*;
#(
  parameter  int unsigned CLK_FREQ   = 50_000_000,
  parameter  int unsigned PWM_FREQ   = 1_000,
  parameter  int unsigned MAX_PERIOD = 2 * CLK_FREQ / PWM_FREQ,
  parameter  int unsigned FILTER_LEN = 4,
  localparam int unsigned CNT_W      = $clog2(MAX_PERIOD + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pwm_in,
  output logic [CNT_W-1:0] period_cnt,
  output logic [CNT_W-1:0] high_cnt,
  output logic [7:0]       duty_cycle,
  output logic             valid,
  output logic             timeout
);

  localparam int unsigned NUM_W = CNT_W + 7;

  logic             sync1, sync2, lvl, lvl_d, rise, fall, at_max;
  logic [CNT_W-1:0] cnt, high_tmp, meas_period, meas_high;
  state_t           state, state_n;
  logic             latch_high, close, to_evt, start;
  logic             div_busy, div_done;
  logic [NUM_W-1:0] num;
  logic [7:0]       quot;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      lvl_d <= 1'b0;
    end else begin
      sync1 <= pwm_in;
      sync2 <= sync1;
      lvl_d <= lvl;
    end
  end

`ifdef PWM_CAP_FILTER_EN
  localparam int unsigned FCNT_W = $clog2(FILTER_LEN + 1);
  logic [FCNT_W-1:0] fcnt;
  logic              filt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fcnt <= '0;
      filt <= 1'b0;
    end else if (sync2 == filt) begin
      fcnt <= '0;
    end else if (fcnt == FCNT_W'(FILTER_LEN - 1)) begin
      filt <= sync2;
      fcnt <= '0;
    end else begin
      fcnt <= fcnt + 1'b1;
    end
  end

  assign lvl = filt;
`else
  assign lvl = sync2;
`endif

  assign rise   = lvl & ~lvl_d;
  assign fall   = ~lvl & lvl_d;
  assign at_max = (cnt == CNT_W'(MAX_PERIOD));

  always_ff @(posedge clk or posedge rst) begin
    if (rst)          cnt <= '0;
    else if (rise)    cnt <= CNT_W'(1);
    else if (!at_max) cnt <= cnt + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // IDLE refires only until timeout is set, so a static line reports once.
  always_comb begin
    state_n    = state;
    latch_high = 1'b0;
    close      = 1'b0;
    to_evt     = 1'b0;
    case (state)
      IDLE: begin
        if (rise) state_n = HIGH;
        else if (at_max && !timeout) to_evt = 1'b1;
      end
      HIGH: begin
        if (at_max) begin
          to_evt  = 1'b1;
          state_n = IDLE;
        end else if (fall) begin
          latch_high = 1'b1;
          state_n    = LOW;
        end
      end
      LOW: begin
        if (rise) begin
          close   = 1'b1;
          state_n = HIGH;
        end else if (at_max) begin
          to_evt  = 1'b1;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign start = close & ~div_busy;
  assign num   = NUM_W'(high_tmp) * NUM_W'(PERCENT_SCALE);

  pwm_div #(
    .NUM_W (NUM_W),
    .DEN_W (CNT_W),
    .QUOT_W(8)
  ) u_div (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .num  (num),
    .den  (cnt),
    .busy (div_busy),
    .done (div_done),
    .quot (quot)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      high_tmp    <= '0;
      meas_period <= '0;
      meas_high   <= '0;
      period_cnt  <= '0;
      high_cnt    <= '0;
      duty_cycle  <= '0;
      valid       <= 1'b0;
      timeout     <= 1'b0;
    end else begin
      valid <= 1'b0;
      if (latch_high) high_tmp <= cnt;
      if (start) begin
        meas_period <= cnt;
        meas_high   <= high_tmp;
      end
      if (to_evt) begin
        timeout    <= 1'b1;
        period_cnt <= '0;
        high_cnt   <= '0;
        duty_cycle <= lvl ? 8'(PERCENT_SCALE) : '0;
        valid      <= 1'b1;
      end else if (div_done) begin
        period_cnt <= meas_period;
        high_cnt   <= meas_high;
        duty_cycle <= quot;
        timeout    <= 1'b0;
        valid      <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pwm_capture.sv
// Scoreboard bench for pwm_capture: the stimulus driver models each closing rise
// and pushes expected results; a negedge monitor pops and compares on valid.
module tb_pwm_capture;

  localparam int CLK_FREQ = 10_000;
  localparam int PWM_FREQ = 100;
  localparam int CNT_W    = 8;
  localparam int DIV_GAP  = 16;
`ifdef PWM_CAP_FILTER_EN
  localparam int LAT    = 22;
  localparam int HALF   = 4;
  localparam int NARROW = 5;
`else
  localparam int LAT    = 18;
  localparam int HALF   = 3;
  localparam int NARROW = 1;
`endif

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             pwm_in = 1'b0;
  logic [CNT_W-1:0] period_cnt, high_cnt;
  logic [7:0]       duty_cycle;
  logic             valid, timeout;

  pwm_capture #(
    .CLK_FREQ  (CLK_FREQ),
    .PWM_FREQ  (PWM_FREQ),
    .FILTER_LEN(4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .pwm_in    (pwm_in),
    .period_cnt(period_cnt),
    .high_cnt  (high_cnt),
    .duty_cycle(duty_cycle),
    .valid     (valid),
    .timeout   (timeout)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int period;
    int high;
    int duty;
    int to;
    int at;
  } exp_t;

  exp_t sbq[$];
  int tests = 0;
  int fails = 0;

  int prev_rise = 0, prev_high = 0, last_start = 0;
  bit have_prev = 0, have_start = 0;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_exp(input int p, input int h, input int d, input int t, input int at);
    exp_t e;
    e.period = p; e.high = h; e.duty = d; e.to = t; e.at = at;
    sbq.push_back(e);
  endtask

  // Monitor: every valid pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst && valid) begin
      if (sbq.size() == 0) begin
        check("unexpected_valid", 1, 0);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        check("period_cnt", int'(period_cnt), e.period);
        check("high_cnt",   int'(high_cnt),   e.high);
        check("duty_cycle", int'(duty_cycle), e.duty);
        check("timeout",    int'(timeout),    e.to);
        if (e.at >= 0) check("valid_cycle", cyc, e.at);
      end
    end
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic note_rise();
    int c, p;
    c = cyc;
    if (have_prev) begin
      p = c - prev_rise;
      if (!have_start || (c - last_start) >= DIV_GAP) begin
        push_exp(p, prev_high, (prev_high * 100) / p, 0, c + LAT);
        last_start = c;
        have_start = 1;
      end
    end
    prev_rise = c;
    have_prev = 1;
  endtask

  task automatic set_line(input bit v);
    if (v && !pwm_in) note_rise();
    if (!v && pwm_in) prev_high = cyc - prev_rise;
    pwm_in = v;
  endtask

  task automatic period(input int hi, input int lo);
    set_line(1);
    wait_cycles(hi);
    set_line(0);
    wait_cycles(lo);
  endtask

  task automatic hold_timeout(input bit v);
    set_line(v);
    push_exp(0, 0, v ? 100 : 0, 1, -1);
    have_prev = 0;
    wait_cycles(300);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sbq.size() != 0 && n < 200) begin
      wait_cycles(1);
      n++;
    end
    check("pending_valids", sbq.size(), 0);
    sbq.delete();
  endtask

  task automatic model_reset();
    sbq.delete();
    have_prev  = 0;
    have_start = 0;
    pwm_in     = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    model_reset();
    wait_cycles(3);
    rst = 1'b0;
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "_valid"},      int'(valid),      0);
    check({tag, "_period_cnt"}, int'(period_cnt), 0);
    check({tag, "_high_cnt"},   int'(high_cnt),   0);
    check({tag, "_duty_cycle"}, int'(duty_cycle), 0);
    check({tag, "_timeout"},    int'(timeout),    0);
  endtask

`ifdef PWM_CAP_FILTER_EN
  task automatic glitch_period();
    set_line(1);
    wait_cycles(10);
    pwm_in = 1'b0;
    wait_cycles(2);
    pwm_in = 1'b1;
    wait_cycles(18);
    set_line(0);
    wait_cycles(30);
    pwm_in = 1'b1;
    wait_cycles(2);
    pwm_in = 1'b0;
    wait_cycles(38);
  endtask
`endif

  initial begin
    wait_cycles(2);
    check_cleared("reset");
    rst = 1'b0;

    // Steady 30/70, then 80/80, then narrow high pulses, ending with a static high line.
    do_reset();
    repeat (4) period(30, 70);
    repeat (3) period(80, 80);
    repeat (3) period(NARROW, 100 - NARROW);
    hold_timeout(1);
    drain();
    check("timeout_level_high", int'(timeout), 1);

    // Line static high straight out of reset.
    do_reset();
    hold_timeout(1);
    drain();

    // Line static low out of reset, then a 40/60 waveform clears timeout.
    do_reset();
    hold_timeout(0);
    drain();
    check("timeout_level_low", int'(timeout), 1);
    repeat (3) period(40, 60);
    drain();
    check("timeout_cleared", int'(timeout), 0);
    hold_timeout(0);
    drain();

    // Reset while HIGH with a division in flight.
    do_reset();
    repeat (3) period(30, 70);
    set_line(1);
    wait_cycles(10);
    rst = 1'b1;
    #1;
    check_cleared("midreset");
    model_reset();
    wait_cycles(3);
    rst = 1'b0;
    repeat (3) period(30, 70);
    hold_timeout(0);
    drain();

    // Periods shorter than the divider latency.
    do_reset();
    repeat (12) period(HALF, HALF);
    hold_timeout(0);
    drain();

`ifdef PWM_CAP_FILTER_EN
    do_reset();
    repeat (4) glitch_period();
    hold_timeout(0);
    drain();
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation still running at cycle %0d, expected completion", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
